// File: rtl/semaphore_pkg.sv
// Shared types and default phase durations for the intersection semaphore.
package semaphore_pkg;

   typedef enum logic [2:0] {
      StGreen,
      StYellow,
      StAllRed,
      StWalk,
      StFlash
   } state_e;

   localparam int unsigned DefClkFreq   = 4;
   localparam int unsigned DefNumWays   = 2;
   localparam int unsigned DefGreenS    = 7;
   localparam int unsigned DefMinGreenS = 2;
   localparam int unsigned DefYellowS   = 2;
   localparam int unsigned DefAllRedS   = 1;
   localparam int unsigned DefWalkS     = 5;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Cycle counter for the current phase: clears to zero, counts up to limit and holds there.
module phase_timer #(
   parameter int unsigned Width = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [Width-1:0] limit,
   output logic [Width-1:0] count,
   output logic             done
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count_q <= '0;
      end else if (!done) begin
         count_q <= count_q + Width'(1);
      end
   end

   assign done  = (count_q >= limit);
   assign count = count_q;

endmodule

// File: rtl/intersection_semaphore.sv
// Traffic-light controller for NUM_WAYS approaches with a shared pedestrian walk phase.
// Night flashing mode is built in when SEMAPHORE_NIGHT_MODE_EN is defined.
module intersection_semaphore
   import semaphore_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = DefClkFreq,
   parameter int unsigned NUM_WAYS    = DefNumWays,
   parameter int unsigned GREEN_S     = DefGreenS,
   parameter int unsigned MIN_GREEN_S = DefMinGreenS,
   parameter int unsigned YELLOW_S    = DefYellowS,
   parameter int unsigned ALLRED_S    = DefAllRedS,
   parameter int unsigned WALK_S      = DefWalkS
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef SEMAPHORE_NIGHT_MODE_EN
   input  logic                night,
`endif
   input  logic [NUM_WAYS-1:0] pedestrian,
   output logic [NUM_WAYS-1:0] green,
   output logic [NUM_WAYS-1:0] yellow,
   output logic [NUM_WAYS-1:0] red,
   output logic                walk,
   output logic                ped_pending
);

   localparam int unsigned GreenCyc  = GREEN_S * CLK_FREQ;
   localparam int unsigned MinCyc    = MIN_GREEN_S * CLK_FREQ;
   localparam int unsigned YellowCyc = YELLOW_S * CLK_FREQ;
   localparam int unsigned AllRedCyc = ALLRED_S * CLK_FREQ;
   localparam int unsigned WalkCyc   = WALK_S * CLK_FREQ;
   localparam int unsigned FlashHalf = (CLK_FREQ / 2 > 0) ? CLK_FREQ / 2 : 1;
   localparam int unsigned MaxCyc    = max_u(max_u(GreenCyc, WalkCyc),
                                             max_u(max_u(YellowCyc, AllRedCyc), FlashHalf));
   localparam int unsigned CntW      = $clog2(MaxCyc + 1);
   localparam int unsigned CurW      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   localparam logic [CntW-1:0] GreenLim  = CntW'(GreenCyc - 1);
   localparam logic [CntW-1:0] MinLim    = CntW'(MinCyc - 1);
   localparam logic [CntW-1:0] YellowLim = CntW'(YellowCyc - 1);
   localparam logic [CntW-1:0] AllRedLim = CntW'(AllRedCyc - 1);
   localparam logic [CntW-1:0] WalkLim   = CntW'(WalkCyc - 1);
   localparam logic [CntW-1:0] FlashLim  = CntW'(FlashHalf - 1);

   state_e              state_q, state_d;
   logic [CurW-1:0]     cur_q, cur_d;
   logic                req_q, req_d;
   logic [CntW-1:0]     limit, count;
   logic                done, clear;
   logic [NUM_WAYS-1:0] green_q, green_d, yellow_q, yellow_d, red_q, red_d;
   logic                walk_q, walk_d;
`ifdef SEMAPHORE_NIGHT_MODE_EN
   logic                blink_q, blink_d;
   logic                flash_exit_q, flash_exit_d;
`endif

   function automatic logic [CurW-1:0] next_way(input logic [CurW-1:0] w);
      return (w == CurW'(NUM_WAYS - 1)) ? '0 : w + CurW'(1);
   endfunction

   phase_timer #(
      .Width (CntW)
   ) u_phase_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .limit (limit),
      .count (count),
      .done  (done)
   );

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      req_d   = req_q;
      limit   = GreenLim;
      case (state_q)
         StGreen: begin
            req_d = req_q | (|pedestrian);
            // A latched request shortens green once the minimum has elapsed.
            if (done || (req_q && count >= MinLim)) state_d = StYellow;
         end
         StYellow: begin
            limit = YellowLim;
            req_d = req_q | (|pedestrian);
            if (done) state_d = StAllRed;
         end
         StAllRed: begin
            limit = AllRedLim;
            req_d = req_q | (|pedestrian);
            if (done) begin
`ifdef SEMAPHORE_NIGHT_MODE_EN
               if (flash_exit_q) begin
                  state_d = StGreen;
               end else
`endif
               if (req_q) begin
                  state_d = StWalk;
                  req_d   = 1'b0;
               end else begin
                  state_d = StGreen;
                  cur_d   = next_way(cur_q);
               end
            end
         end
         StWalk: begin
            limit = WalkLim;
            if (done) begin
               state_d = StGreen;
               cur_d   = next_way(cur_q);
            end
         end
`ifdef SEMAPHORE_NIGHT_MODE_EN
         StFlash: begin
            limit = FlashLim;
            req_d = 1'b0;
            if (!night) begin
               state_d = StAllRed;
               cur_d   = '0;
            end
         end
`endif
         default: state_d = StGreen;
      endcase
`ifdef SEMAPHORE_NIGHT_MODE_EN
      if (night && state_q != StFlash) begin
         state_d = StFlash;
         req_d   = 1'b0;
      end
`endif
   end

`ifdef SEMAPHORE_NIGHT_MODE_EN
   // The flash half-period reuses the phase timer by restarting it on every toggle.
   assign clear        = (state_d != state_q) || (state_q == StFlash && done);
   assign flash_exit_d = (state_q == StFlash) || (state_q == StAllRed && flash_exit_q);

   always_comb begin
      blink_d = blink_q;
      if (state_q != StFlash) blink_d = 1'b1;
      else if (done)          blink_d = ~blink_q;
   end
`else
   assign clear = (state_d != state_q);
`endif

   always_comb begin
      green_d  = '0;
      yellow_d = '0;
      red_d    = '1;
      walk_d   = 1'b0;
      case (state_q)
         StGreen: begin
            green_d[cur_q] = 1'b1;
            red_d[cur_q]   = 1'b0;
         end
         StYellow: begin
            yellow_d[cur_q] = 1'b1;
            red_d[cur_q]    = 1'b0;
         end
         StWalk: walk_d = 1'b1;
`ifdef SEMAPHORE_NIGHT_MODE_EN
         StFlash: begin
            red_d    = '0;
            yellow_d = {NUM_WAYS{blink_q}};
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StGreen;
         cur_q    <= '0;
         req_q    <= 1'b0;
         green_q  <= NUM_WAYS'(1);
         yellow_q <= '0;
         red_q    <= ~NUM_WAYS'(1);
         walk_q   <= 1'b0;
`ifdef SEMAPHORE_NIGHT_MODE_EN
         blink_q      <= 1'b1;
         flash_exit_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         req_q    <= req_d;
         green_q  <= green_d;
         yellow_q <= yellow_d;
         red_q    <= red_d;
         walk_q   <= walk_d;
`ifdef SEMAPHORE_NIGHT_MODE_EN
         blink_q      <= blink_d;
         flash_exit_q <= flash_exit_d;
`endif
      end
   end

   assign green       = green_q;
   assign yellow      = yellow_q;
   assign red         = red_q;
   assign walk        = walk_q;
   assign ped_pending = req_q;

endmodule

// File: doc/intersection_semaphore.md
INTERSECTION_SEMAPHORE -- requirements
Module: intersection_semaphore

Interface
REQ-001 Parameter CLK_FREQ, default 4: clock cycles per second.
REQ-002 Parameter NUM_WAYS, default 2, legal range 2..4: number of vehicle approaches.
REQ-003 Parameters GREEN_S=7, MIN_GREEN_S=2, YELLOW_S=2, ALLRED_S=1, WALK_S=5: phase durations in seconds, each >=1, MIN_GREEN_S<=GREEN_S.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 pedestrian  input  NUM_WAYS  per-way crossing request, any pulse width >=1 cycle.
REQ-007 green, yellow, red  output  NUM_WAYS each  per-way lamps; exactly one of the three is high per way.
REQ-008 walk  output  1  pedestrian walk lamp, all crossings.
REQ-009 ped_pending  output  1  high while a latched request awaits service.

Function
REQ-010 States GREEN, YELLOW, ALLRED, WALK; registered index cur selects the active way.
REQ-011 GREEN: green[cur]=1, all other ways red; lasts GREEN_S*CLK_FREQ cycles, then YELLOW.
REQ-012 GREEN with ped_pending=1: leaves at the later of MIN_GREEN_S*CLK_FREQ cycles in state and the cycle after latching.
REQ-013 YELLOW: yellow[cur]=1, others red; lasts YELLOW_S*CLK_FREQ cycles, then ALLRED.
REQ-014 ALLRED: all red; lasts ALLRED_S*CLK_FREQ cycles; then WALK if ped_pending, else GREEN with cur advanced.
REQ-015 WALK: all red, walk=1; lasts WALK_S*CLK_FREQ cycles; request latch cleared on entry; then GREEN with cur advanced.
REQ-016 cur advances cur+1, wrapping NUM_WAYS-1 -> 0.
REQ-017 Request latch: OR of pedestrian bits sampled each clock in GREEN, YELLOW, ALLRED; presses during WALK ignored.
REQ-018 Press in the same cycle ALLRED expires is not served by the immediately following phase; it forces WALK after the next ALLRED.
REQ-019 Phase counter reloads to zero on every state change; width $clog2(max duration*CLK_FREQ+1).
REQ-020 All outputs registered; lamp outputs change the cycle after the state register changes (one-cycle latency).

Reset
REQ-021 rst_n=0 at a clock edge: state GREEN, cur=0, counter 0, request latch 0.
REQ-022 Reset output values: green=one-hot bit0, yellow=0, red=all bits except bit0, walk=0, ped_pending=0.
REQ-023 Reset asserted mid-phase overrides all pending transitions and requests in that same edge.

Configuration
REQ-024 Macro SEMAPHORE_NIGHT_MODE_EN defined: adds input night (1 bit) and state FLASH.
REQ-025 With macro, night=1 enters FLASH next cycle from any state: red=0, green=0, walk=0, all yellow bits toggle every CLK_FREQ/2 cycles starting high, request latch cleared.
REQ-026 With macro, night falling: FLASH -> ALLRED for ALLRED_S*CLK_FREQ cycles, then GREEN with cur=0.
REQ-027 Without macro: no night port, no FLASH state, behaviour identical to REQ-010..023.

Structure
REQ-028 Shared package semaphore_pkg holds the state enum (GREEN, YELLOW, ALLRED, WALK, FLASH) and the default duration constants.
REQ-029 One sub-module phase_timer: loadable cycle counter with clear and done output, instantiated once.

Verification (CLK_FREQ=4, NUM_WAYS=2, defaults)
REQ-030 Reset then no press -> green=01 for 28 cycles, yellow=01 for 8, all red 4, green=10 for 28, wrap back to way 0.
REQ-031 Press pedestrian[1] at green cycle 3 -> yellow at cycle 8 of green, all red 4 cycles, walk=1 for 20 cycles, then green=10.
REQ-032 Press during WALK only -> no second WALK; next cycle follows REQ-030 timing.
REQ-033 Press on the final ALLRED cycle -> next phase GREEN without WALK; WALK occurs after the following ALLRED.
REQ-034 rst_n=0 for one cycle mid-YELLOW with pending request -> outputs equal REQ-022 values next cycle, ped_pending=0.
REQ-035 SEMAPHORE_NIGHT_MODE_EN defined, night=1 during GREEN -> yellow=11 alternating every 2 cycles; night=0 -> 4 cycles all red, then green=01.
